// File: rtl/tof_pkg.sv
// Shared definitions for the ToF command scheduler: opcodes, per-sensor status
// codes, scheduler states and the opcode legality helper.
package tof_pkg;

  localparam int TOF_N_SENSORS = 8;

  localparam logic [3:0] OP_NOP           = 4'd0;
  localparam logic [3:0] OP_INIT          = 4'd1;
  localparam logic [3:0] OP_START_RANGING = 4'd2;
  localparam logic [3:0] OP_STOP_RANGING  = 4'd3;
  localparam logic [3:0] OP_FW_LOAD       = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DONE  = 2'b01,
    ST_BUSY  = 2'b10,
    ST_ERROR = 2'b11
  } tof_status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_HOLD
  } sched_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_INIT, OP_START_RANGING, OP_STOP_RANGING, OP_FW_LOAD};
  endfunction

endpackage

// File: rtl/tof_cmd_scheduler_if.sv
// Sensor-side bus of the scheduler: command broadcast, completion pulses and
// the shared firmware ROM request/grant path.
interface tof_cmd_scheduler_if #(
  parameter int N_SENSORS = 8,
  parameter int FW_AW     = 15
);
  logic [3:0]                 cmd_op;
  logic [N_SENSORS-1:0]       cmd_start;
  logic [N_SENSORS-1:0]       fsm_done;
  logic [N_SENSORS-1:0]       fsm_err;
  logic [N_SENSORS-1:0]       fw_req;
  logic [N_SENSORS*FW_AW-1:0] fw_addr_in;
  logic [N_SENSORS-1:0]       fw_gnt;
  logic [FW_AW-1:0]           fw_rom_addr;
  logic [N_SENSORS-1:0]       fw_rd_valid;

  modport master (
    output cmd_op, cmd_start, fw_gnt, fw_rom_addr, fw_rd_valid,
    input  fsm_done, fsm_err, fw_req, fw_addr_in
  );

  modport slave (
    input  cmd_op, cmd_start, fw_gnt, fw_rom_addr, fw_rd_valid,
    output fsm_done, fsm_err, fw_req, fw_addr_in
  );
endinterface

// File: rtl/tof_fw_rr_arbiter.sv
// Round-robin arbiter for the single-port firmware ROM: holds a grant for the
// whole burst, muxes the owner's address and delays the grant as data-valid.
module tof_fw_rr_arbiter
  import tof_pkg::*;
#(
  parameter int N_SENSORS = TOF_N_SENSORS,
  parameter int FW_AW     = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SENSORS-1:0]       req,
  input  logic [N_SENSORS*FW_AW-1:0] addr_in,
  output logic [N_SENSORS-1:0]       gnt,
  output logic [FW_AW-1:0]           rom_addr,
  output logic [N_SENSORS-1:0]       rd_valid
);

  localparam int PW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  logic [N_SENSORS-1:0] gnt_q;
  logic [N_SENSORS-1:0] valid_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        next_idx;
  logic                 found;
  logic                 hold;

  assign hold = |(gnt_q & req);

  // Search starts at the sensor after the previous owner.
  // NOTE: every always_comb output gets a default before the loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    found    = 1'b0;
    next_idx = ptr_q;
    for (int k = 0; k < N_SENSORS; k++) begin
      int cand;
      cand = int'(ptr_q) + k;
      if (cand >= N_SENSORS) cand = cand - N_SENSORS;
      if (!found && req[cand]) begin
        found    = 1'b1;
        next_idx = PW'(cand);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= gnt_q;
      if (!hold) begin
        if (found) begin
          gnt_q <= N_SENSORS'(1) << next_idx;
          ptr_q <= (next_idx == PW'(N_SENSORS - 1)) ? '0 : next_idx + PW'(1);
        end else begin
          gnt_q <= '0;
        end
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (gnt_q[i]) rom_addr = addr_in[i*FW_AW +: FW_AW];
    end
  end

  assign gnt      = gnt_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/tof_cmd_scheduler.sv
// Decodes the AXI command word, runs one command batch at a time over a sensor
// subset with a watchdog, and reports 2-bit status per sensor.
module tof_cmd_scheduler
  import tof_pkg::*;
#(
  parameter int N_SENSORS      = TOF_N_SENSORS,
  parameter int FW_AW          = 15,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            ToF_CMD_in,
  output logic [2*N_SENSORS-1:0] ToF_CMD_out,
  tof_cmd_scheduler_if.master    sens
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e         state;
  logic [3:0]           op_q;
  logic [3:0]           prev_op_q;
  logic [N_SENSORS-1:0] mask_in_q;
  logic [3:0]           cmd_op_q;
  logic [N_SENSORS-1:0] mask_q;
  logic [N_SENSORS-1:0] start_q;
  logic [WD_W-1:0]      wdog_q;
  tof_status_e          status_q    [N_SENSORS];
  tof_status_e          wait_status [N_SENSORS];
  logic                 wait_busy;
  logic                 timeout;
  logic                 cmd_edge;
  logic                 cmd_unused;

  assign cmd_unused = ^ToF_CMD_in[31:4+N_SENSORS];

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      prev_op_q <= '0;
      mask_in_q <= '0;
    end else begin
      op_q      <= ToF_CMD_in[3:0];
      prev_op_q <= op_q;
      mask_in_q <= ToF_CMD_in[4 +: N_SENSORS];
    end
  end

  // Only a 0 -> non-zero opcode transition starts a command.
  assign cmd_edge = (op_q != OP_NOP) && (prev_op_q == OP_NOP);
  assign timeout  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // An error pulse wins over a simultaneous done pulse.
  always_comb begin
    wait_busy = 1'b0;
    for (int i = 0; i < N_SENSORS; i++) begin
      wait_status[i] = status_q[i];
      if (mask_q[i]) begin
        if (sens.fsm_err[i])                       wait_status[i] = ST_ERROR;
        else if (sens.fsm_done[i])                 wait_status[i] = ST_DONE;
        else if (timeout && status_q[i] == ST_BUSY) wait_status[i] = ST_ERROR;
        if (wait_status[i] == ST_BUSY) wait_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_op_q <= '0;
      mask_q   <= '0;
      start_q  <= '0;
      wdog_q   <= '0;
      for (int i = 0; i < N_SENSORS; i++) status_q[i] <= ST_IDLE;
    end else begin
      start_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (cmd_edge) begin
            if (is_legal_op(op_q) && (mask_in_q != '0)) begin
              cmd_op_q <= op_q;
              mask_q   <= mask_in_q;
              start_q  <= mask_in_q;
              for (int i = 0; i < N_SENSORS; i++)
                if (mask_in_q[i]) status_q[i] <= ST_BUSY;
              state <= S_DISPATCH;
            end else begin
              for (int i = 0; i < N_SENSORS; i++)
                if ((mask_in_q == '0) || mask_in_q[i]) status_q[i] <= ST_ERROR;
              state <= S_HOLD;
            end
          end
        end
        S_DISPATCH: begin
          wdog_q <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          status_q <= wait_status;
          wdog_q   <= wdog_q + WD_W'(1);
          if (!wait_busy) state <= S_HOLD;
        end
        S_HOLD: begin
          if (op_q == OP_NOP) state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ToF_CMD_out = '0;
    for (int i = 0; i < N_SENSORS; i++) ToF_CMD_out[2*i +: 2] = status_q[i];
  end

  assign sens.cmd_op    = cmd_op_q;
  assign sens.cmd_start = start_q;

  tof_fw_rr_arbiter #(
    .N_SENSORS(N_SENSORS),
    .FW_AW    (FW_AW)
  ) u_fw_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (sens.fw_req),
    .addr_in (sens.fw_addr_in),
    .gnt     (sens.fw_gnt),
    .rom_addr(sens.fw_rom_addr),
    .rd_valid(sens.fw_rd_valid)
  );

endmodule

// File: doc/tof_cmd_scheduler.md
# tof_cmd_scheduler

Command scheduler between the Zynq AXI command register and the eight per-sensor ToF FSMs. Decodes `ToF_CMD_in`, issues one command batch at a time to a sensor subset, tracks completion with a watchdog, and packs 2-bit per-sensor status into `ToF_CMD_out`. Also round-robin arbitrates the single-port firmware ROM shared by the sensor FSMs during FW download.

## Interface
Parameters:
- `N_SENSORS`, 8, number of ToF channels.
- `FW_AW`, 15, firmware ROM address width.
- `TIMEOUT_CYCLES`, 2_000_000, watchdog limit per batch (clk cycles).

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `ToF_CMD_in` in 32: [3:0] opcode, [11:4] sensor mask, rest ignored.
- `ToF_CMD_out` out 16: status of sensor i at [2i+1:2i].
- `cmd_op` out 4: opcode presented to all sensor FSMs.
- `cmd_start` out N_SENSORS: one-cycle start pulse per sensor.
- `fsm_done` in N_SENSORS: one-cycle completion pulse.
- `fsm_err` in N_SENSORS: one-cycle failure pulse.
- `fw_req` in N_SENSORS: ROM access request, held for burst.
- `fw_addr_in` in N_SENSORS*FW_AW: sensor i address at [i*FW_AW +: FW_AW].
- `fw_gnt` out N_SENSORS: one-hot grant.
- `fw_rom_addr` out FW_AW: address of granted sensor.
- `fw_rd_valid` out N_SENSORS: ROM data (broadcast externally) valid for sensor i.

## Operation
- Opcodes: 0 NOP, 1 INIT, 2 START_RANGING, 3 STOP_RANGING, 5 FW_LOAD; others illegal.
- Status codes: 00 IDLE, 01 DONE, 10 BUSY, 11 ERROR.
- FSM states: IDLE, DISPATCH, WAIT, HOLD.
- IDLE: accepts a command only on opcode 0→non-zero transition (previous registered opcode 0). Legal opcode, mask≠0 → latch op and mask, go DISPATCH. Illegal opcode or mask=0 → status of masked sensors (all sensors if mask=0) = ERROR, go HOLD.
- DISPATCH (1 cycle): `cmd_start` = latched mask, masked status → BUSY, clear watchdog, go WAIT.
- WAIT: per masked sensor, `fsm_done` → DONE, `fsm_err` → ERROR; both same cycle → ERROR. Pulses from unmasked sensors ignored. When no masked sensor is BUSY → HOLD. Watchdog reaching TIMEOUT_CYCLES → remaining BUSY sensors ERROR, go HOLD.
- HOLD: wait for opcode = 0, then IDLE. Status retained until next accepted command; unmasked sensors keep prior status.
- Opcode change or mask change during WAIT ignored; opcode→0 during WAIT does not abort.
- FW arbiter: round-robin, pointer starts at sensor 0. Grant held while granted `fw_req` high; on release, next requester after previous owner granted the following cycle (1 idle cycle between bursts permitted, not required). No requests → `fw_gnt`=0.
- `fw_rom_addr` = granted sensor's address, 0 when no grant. `fw_rd_valid[i]` = `fw_gnt[i]` delayed one cycle (1-cycle ROM).

## Timing
- Reset: state IDLE, `ToF_CMD_out`=0, `cmd_start`=0, `cmd_op`=0, `fw_gnt`=0, `fw_rom_addr`=0, `fw_rd_valid`=0, RR pointer 0, watchdog 0.
- Command write at cycle T (registered input) → edge seen T+1 → DISPATCH T+1 → `cmd_start` and BUSY visible at T+2.
- `fsm_done` at cycle D → DONE visible D+1.
- `cmd_op` registered, stable from DISPATCH through HOLD.
- Watchdog counts in WAIT only; width ceil(log2(TIMEOUT_CYCLES+1)).
- Request at cycle R with bus idle → `fw_gnt` at R+1 → `fw_rd_valid` at R+2.
- `rst` mid-batch: all outputs to reset values next cycle; sensor FSMs are reset independently.

## Structure
- Shared package `tof_pkg`: opcode constants, status constants, N_SENSORS default.
- Sub-module `tof_fw_rr_arbiter` (round-robin grant + address mux + valid delay); scheduler FSM in top-level `tof_cmd_scheduler`.

## Test plan
- Reset, write 0x0000_0FF1 (INIT all) → `cmd_start`=0xFF once, `ToF_CMD_out`=0xAAAA; done pulses all → 0x5555; write 0 → IDLE.
- Write 0x015 (FW_LOAD sensor 0) → status[1:0]=10; sensor 0 requests 300 words → `fw_gnt`=0x01, `fw_rd_valid[0]` lags one cycle, addresses passed through.
- `fw_req`=0x83 simultaneously with pointer 0 → grants in order 0, 1, 7, then 0 again if re-requesting.
- Mask 0x03, INIT; sensor 0 done, sensor 1 silent, TIMEOUT_CYCLES=100 → sensor 0 DONE, sensor 1 ERROR after 100 cycles, `ToF_CMD_out`=0x000D.
- Opcode 0x7 mask 0x01 → status[1:0]=11, no `cmd_start`; holding opcode non-zero → no re-trigger.
- `rst` asserted during WAIT with FW grant active → next cycle all outputs 0; new INIT accepted normally.
